pwm_generate: RTL and testbench
===============================

# pwm_generate

Generates the ultrasonic-style pulse-width signal that `pwm_measure` decodes: a frame of fixed period in which the output is high for `value × CYCLES_PER_UNIT` clock cycles. It is the transmit end of the pulse-width link. Upstream logic hands it 8-bit values over a valid/ready handshake. It drives a single-bit `pwm_out` that a `pwm_measure` instance converts back to the same value.

## Interface
- `CYCLES_PER_UNIT`, 1664: clock cycles of high time per unit of `value`.
- `PERIOD_CYCLES`, 500_000: frame length in clock cycles (50 ms at 10 MHz).
- `clk`  in  1  system clock (10 MHz nominal).
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  allow frames to start; sampled at frame boundaries only.
- `value`  in  8  requested pulse width in units.
- `value_valid`  in  1  `value` is presented.
- `value_ready`  out  1  pending buffer empty; a transfer occurs on `value_valid && value_ready`.
- `pwm_out`  out  1  registered pulse output.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse on the last cycle of every frame.

## Operation
- Storage:
  - a one-deep pending register (`pend_val`, `pend_full`);
  - an active register (`act_val`);
  - a 19-bit phase counter. Counter width must cover `PERIOD_CYCLES-1`.
- Handshake:
  - `value_ready = !pend_full`.
  - On a transfer, `pend_val <= value` and `pend_full <= 1`.
  - `value` is ignored when no transfer occurs.
- Frame start, in IDLE with `enable=1`, or on the last cycle of a frame with `enable=1`:
  - if `pend_full`, then `act_val <= pend_val` and `pend_full <= 0`;
  - otherwise `act_val` is retained, so the last value repeats.
- A transfer in the same cycle as frame start lands in pending and is used by the next frame.
- High time: `hi = act_val × CYCLES_PER_UNIT`, computed in 19+ bits.
  - If `hi >= PERIOD_CYCLES`, clamp to `PERIOD_CYCLES-1` so every frame has at least one low cycle.
- States:
  - IDLE: `pwm_out=0`, phase=0.
    - Frame start → HIGH, or → LOW if `hi=0`.
  - HIGH: `pwm_out=1`; phase increments each cycle.
    - When phase reaches `hi-1` → LOW.
  - LOW: `pwm_out=0`; phase increments each cycle.
    - At phase `PERIOD_CYCLES-1`, assert `frame_done`.
    - If `enable=1`, perform frame start: phase=0 → HIGH, or LOW if `hi=0`.
    - Otherwise → IDLE.
- `enable` deasserted mid-frame never truncates a frame; the current frame completes.
- `value=0` gives a frame with `pwm_out` low throughout, but `frame_done` still fires.
- `busy = (state != IDLE)`.

## Timing
- Reset values: state IDLE, phase 0, `act_val=0`, `pend_full=0`, `pend_val=0`.
  - Outputs after reset: `pwm_out=0`, `busy=0`, `frame_done=0`, `value_ready=1`.
- Reset mid-frame: `pwm_out` is low on the next edge, and the pending value is discarded.
- `value_ready` falls the cycle after a transfer. It rises the cycle after the frame start that consumes the pending value.
- Frame-start latency: `enable` sampled high in IDLE → `pwm_out` rises on the following edge.
- High time is exactly `hi` cycles. Frame length is exactly `PERIOD_CYCLES` cycles, measured rising edge to rising edge.
- Back-to-back frames under continuous `enable` have no idle gap.
- `frame_done` coincides with the final LOW cycle of the frame.
- All outputs are registered; there are no combinational paths from inputs to `pwm_out`.

## Test plan
- Reset, then transfer `value=4` and hold `enable=1`:
  - `pwm_out` high for exactly 6656 cycles, low for 493_344;
  - `frame_done` pulses every 500_000 cycles.
- Loopback into `pwm_measure #(1664)` with the sequence 4, 1, 2, 4, 3, 4, one value per frame:
  - `distance` reports 4, 1, 2, 4, 3, 4 in order.
- `value=0`:
  - `pwm_out` stays 0 for the full frame;
  - `frame_done` still pulses at cycle 499_999.
- Handshake:
  - hold `value_valid` with 7, then 9, during a frame: 7 is accepted and `value_ready` drops;
  - 9 stalls until the next frame start consumes 7;
  - the frames run at 7, then 9.
- Deassert `enable` mid-HIGH: the frame completes at full length, then `busy=0` and `pwm_out=0`.
  - Assert reset mid-HIGH instead: `pwm_out=0` on the next edge and `value_ready=1`.
- Override to `CYCLES_PER_UNIT=2000` with `value=255`:
  - high time clamps to 499_999 cycles;
  - exactly one low cycle per frame.

Source files
------------

// File: rtl/pwm_generate.sv
// Pulse-width frame generator: each PERIOD_CYCLES frame is high for
// value*CYCLES_PER_UNIT cycles (clamped to leave one low cycle).
module pwm_generate #(
    parameter int CYCLES_PER_UNIT = 1664,
    parameter int PERIOD_CYCLES   = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] value,
    input  logic       value_valid,
    output logic       value_ready,
    output logic       pwm_out,
    output logic       busy,
    output logic       frame_done
);
    localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    function automatic logic [PW-1:0] hi_of(input logic [7:0] v);
        logic [31:0] prod;
        prod = 32'(v) * 32'(CYCLES_PER_UNIT);
        if (prod >= 32'(PERIOD_CYCLES))
            return LAST;
        return PW'(prod);
    endfunction

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [7:0]    act_val, pend_val, start_val;
    logic          pend_full;
    logic [PW-1:0] act_hi, start_hi;
    logic          xfer, at_end, start;
    logic          pwm_d, busy_d, done_d;

    // A frame about to start takes the pending value if one is waiting.
    assign start_val = pend_full ? pend_val : act_val;
    assign start_hi  = hi_of(start_val);
    assign act_hi    = hi_of(act_val);
    assign xfer      = value_valid && !pend_full;
    assign at_end    = (state == LOW) && (phase == LAST);
    assign start     = enable && ((state == IDLE) || at_end);

    assign value_ready = !pend_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            act_val   <= '0;
            pend_val  <= '0;
            pend_full <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            if (start)
                act_val <= start_val;
            if (xfer) begin
                pend_val  <= value;
                pend_full <= 1'b1;
            end else if (start) begin
                pend_full <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (start)
                    state_nxt = (start_hi == '0) ? LOW : HIGH;
            end
            HIGH: begin
                phase_nxt = phase + PW'(1);
                if (phase == act_hi - PW'(1))
                    state_nxt = LOW;
            end
            LOW: begin
                if (at_end) begin
                    phase_nxt = '0;
                    if (enable)
                        state_nxt = (start_hi == '0) ? LOW : HIGH;
                    else
                        state_nxt = IDLE;
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered.
    always_comb begin
        pwm_d  = (state_nxt == HIGH);
        busy_d = (state_nxt != IDLE);
        done_d = (state_nxt == LOW) && (phase_nxt == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pwm_out    <= pwm_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end
endmodule

// File: tb/tb_pwm_generate.sv
// Directed bench for pwm_generate with a short frame (40 cycles, 3 cycles/unit).
module tb_pwm_generate;
    localparam int CPU = 3;
    localparam int P   = 40;

    logic       clk = 1'b0;
    logic       reset, enable, value_valid;
    logic [7:0] value;
    logic       value_ready, pwm_out, busy, frame_done;

    pwm_generate #(.CYCLES_PER_UNIT(CPU), .PERIOD_CYCLES(P)) dut (
        .clk(clk), .reset(reset), .enable(enable), .value(value),
        .value_valid(value_valid), .value_ready(value_ready),
        .pwm_out(pwm_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int len;
        bit bad;
    } frame_t;

    typedef struct {
        logic [7:0] v;
        int         exp_hi;
    } vec_t;

    frame_t q[$];
    int     passed = 0;
    int     total  = 0;

    // Frame monitor on the falling edge: records high time, length and
    // whether the high part is a single leading pulse.
    int mon_hi = 0, mon_len = 0;
    bit mon_low = 0, mon_bad = 0;
    always @(negedge clk) begin
        if (reset) begin
            mon_hi = 0; mon_len = 0; mon_low = 0; mon_bad = 0;
        end else if (busy) begin
            mon_len++;
            if (pwm_out) begin
                mon_hi++;
                if (mon_low) mon_bad = 1;
            end else begin
                mon_low = 1;
            end
            if (frame_done) begin
                q.push_back('{hi: mon_hi, len: mon_len, bad: mon_bad});
                mon_hi = 0; mon_len = 0; mon_low = 0; mon_bad = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] v);
        bit done;
        done = 0;
        value = v;
        value_valid = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            if (value_ready) done = 1;
            tick();
        end
        value_valid = 1'b0;
        chk("send_handshake", int'(done), 1);
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 1000 && q.size() < n; k++) tick();
        chk("wait_frames", int'(q.size() >= n), 1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            if (frame_done) seen = 1;
        end
        chk("wait_frame_done", int'(seen), 1);
    endtask

    vec_t tbl[8];

    initial begin
        // 13*3 = 39 is exactly PERIOD-1; 14 and 255 exceed it and clamp.
        tbl[0] = '{8'd4,   12};
        tbl[1] = '{8'd1,    3};
        tbl[2] = '{8'd2,    6};
        tbl[3] = '{8'd0,    0};
        tbl[4] = '{8'd13,  39};
        tbl[5] = '{8'd14,  39};
        tbl[6] = '{8'd255, 39};
        tbl[7] = '{8'd255, 39};

        reset = 1'b1; enable = 1'b0; value_valid = 1'b0; value = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_pwm_out", int'(pwm_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_value_ready", int'(value_ready), 1);

        // First value while idle: accepted, but nothing starts without enable.
        value = tbl[0].v; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        chk("xfer_ready_low", int'(value_ready), 0);
        chk("idle_no_start_pwm", int'(pwm_out), 0);
        chk("idle_no_start_busy", int'(busy), 0);
        q.delete();
        enable = 1'b1;
        tick();
        chk("start_pwm_high", int'(pwm_out), 1);
        chk("start_busy", int'(busy), 1);
        chk("start_ready_back", int'(value_ready), 1);

        for (int i = 1; i < 8; i++) send(tbl[i].v);
        wait_frames(8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_hi", i), q[i].hi, tbl[i].exp_hi);
            chk($sformatf("tbl%0d_len", i), q[i].len, P);
            chk($sformatf("tbl%0d_shape", i), int'(q[i].bad), 0);
        end

        // Handshake: 7 accepted mid-frame, 9 stalls until 7 is consumed.
        q.delete();
        value = 8'd7; value_valid = 1'b1;
        tick();
        chk("hs_accept7_ready", int'(value_ready), 0);
        value = 8'd9;
        repeat (5) tick();
        chk("hs_stall9_ready", int'(value_ready), 0);
        wait_done();
        chk("hs_last_cycle_ready", int'(value_ready), 0);
        tick();
        chk("hs_consume7_ready", int'(value_ready), 1);
        chk("hs_consume7_pwm", int'(pwm_out), 1);
        tick();
        chk("hs_accept9_ready", int'(value_ready), 0);
        value_valid = 1'b0;
        wait_frames(3);
        chk("hs_frame7_hi", q[1].hi, 21);
        chk("hs_frame9_hi", q[2].hi, 27);
        chk("hs_frame9_len", q[2].len, P);

        // Drop enable mid-HIGH: the frame still runs to full length.
        repeat (3) tick();
        chk("dis_in_high", int'(pwm_out), 1);
        q.delete();
        enable = 1'b0;
        wait_frames(1);
        chk("dis_frame_hi", q[0].hi, 27);
        chk("dis_frame_len", q[0].len, P);
        chk("dis_idle_busy", int'(busy), 0);
        chk("dis_idle_pwm", int'(pwm_out), 0);
        tick();
        chk("dis_stays_idle", int'(busy), 0);

        // Reset mid-HIGH discards the pending value and the active value.
        value = 8'd5; value_valid = 1'b1; enable = 1'b1;
        tick();
        value_valid = 1'b0;
        chk("rmid_pend_full", int'(value_ready), 0);
        chk("rmid_high", int'(pwm_out), 1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rmid_pwm_low", int'(pwm_out), 0);
        chk("rmid_ready", int'(value_ready), 1);
        chk("rmid_busy", int'(busy), 0);
        reset = 1'b0;
        q.delete();
        wait_frames(1);
        chk("zero_frame_hi", q[0].hi, 0);
        chk("zero_frame_len", q[0].len, P);
        enable = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
